// File: rtl/dispatch_ctrl.sv
// Dispatch sequencer: allocates ROB tags and steers decoded instructions into reservation stations.
// Optional DISPATCH_PERF_EN adds saturating stall counters for ROB-full and no-credit stalls.
module dispatch_ctrl #(
  parameter int ROB_DEPTH = 64,
  parameter int RS_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_rs_dest,
  output logic       in_ready,
  output logic [5:0] dest_rob,
  output logic       rob_alloc,
  output logic [3:0] rs_we,
  input  logic [3:0] rs_release,
  input  logic       rob_commit,
  input  logic       flush,
  output logic       rob_full,
  output logic       rob_empty,
  output logic       err
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0] perf_stall_rob,
  output logic [31:0] perf_stall_rs
`endif
);

  localparam logic [5:0] TAG_MAX  = 6'(ROB_DEPTH - 1);
  localparam logic [6:0] ROB_CAP  = 7'(ROB_DEPTH);
  localparam logic [3:0] RS_FULL  = 4'(RS_DEPTH);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e     state_q, state_d;
  logic [5:0] head_q, head_d;
  logic [5:0] tail_q, tail_d;
  logic [6:0] count_q, count_d;
  logic [3:0] credit_q [4];
  logic [3:0] credit_d [4];
  logic       err_q, err_d;

  logic legal, has_credit, fire, commit_ok, commit_bad;

  function automatic logic [5:0] next_ptr(input logic [5:0] p);
    return (p == TAG_MAX) ? 6'd0 : p + 6'd1;
  endfunction

  // A zero select is a nop allocation and needs no station credit.
  always_comb begin
    legal      = (in_rs_dest & (in_rs_dest - 4'd1)) == 4'd0;
    has_credit = (in_rs_dest == 4'd0);
    for (int i = 0; i < 4; i++) begin
      if (in_rs_dest[i] && credit_q[i] != 4'd0) has_credit = 1'b1;
    end
  end

  assign rob_full   = (count_q == ROB_CAP);
  assign rob_empty  = (count_q == 7'd0);
  assign fire       = in_valid && state_q == RUN && !flush && !rob_full && legal && has_credit;
  assign commit_ok  = rob_commit && state_q == RUN && count_q != 7'd0;
  assign commit_bad = rob_commit && state_q == RUN && count_q == 7'd0;

  assign in_ready  = fire;
  assign rob_alloc = fire;
  assign rs_we     = fire ? in_rs_dest : 4'd0;
  assign dest_rob  = tail_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    tail_d   = tail_q;
    count_d  = count_q;
    credit_d = credit_q;
    head_d   = commit_ok ? next_ptr(head_q) : head_q;
    err_d    = err_q | (in_valid & ~legal) | commit_bad;
    if (flush) begin
      // Squash everything uncommitted; a same-cycle commit still retires first.
      tail_d  = head_d;
      count_d = 7'd0;
      for (int i = 0; i < 4; i++) credit_d[i] = RS_FULL;
      state_d = FLUSH;
    end else if (state_q == FLUSH) begin
      state_d = RUN;
    end else begin
      tail_d  = fire ? next_ptr(tail_q) : tail_q;
      count_d = count_q + {6'd0, fire} - {6'd0, commit_ok};
      for (int i = 0; i < 4; i++) begin
        if (rs_release[i] && credit_q[i] == RS_FULL) begin
          err_d       = 1'b1;
          credit_d[i] = credit_q[i] - {3'd0, rs_we[i]};
        end else begin
          credit_d[i] = credit_q[i] - {3'd0, rs_we[i]} + {3'd0, rs_release[i]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      head_q  <= 6'd0;
      tail_q  <= 6'd0;
      count_q <= 7'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) credit_q[i] <= RS_FULL;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      err_q    <= err_d;
      credit_q <= credit_d;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_rob_q, stall_rob_d, stall_rs_q, stall_rs_d;
  logic        stall;

  // ROB-full takes priority when attributing a stalled valid cycle.
  always_comb begin
    stall       = in_valid && state_q == RUN && !flush && !fire;
    stall_rob_d = stall_rob_q;
    stall_rs_d  = stall_rs_q;
    if (stall && rob_full && stall_rob_q != 32'hFFFF_FFFF)
      stall_rob_d = stall_rob_q + 32'd1;
    if (stall && !rob_full && legal && !has_credit && stall_rs_q != 32'hFFFF_FFFF)
      stall_rs_d = stall_rs_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_rob_q <= 32'd0;
      stall_rs_q  <= 32'd0;
    end else begin
      stall_rob_q <= stall_rob_d;
      stall_rs_q  <= stall_rs_d;
    end
  end

  assign perf_stall_rob = stall_rob_q;
  assign perf_stall_rs  = stall_rs_q;
`endif

endmodule
